// File: rtl/stepper_seq_ctrl_pkg.sv
// Shared definitions for the queued-segment stepper axis controller.
//   state_t      : segment FSM states
//   cmd_word_w() : width of one packed command word {set_vel, vel, acc, time}
//   acc_w()      : width of the fixed-point position accumulator
package stepper_seq_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Command word layout, LSB first: time | acc | vel | set_vel
  function automatic int unsigned cmd_word_w(int unsigned time_w, int unsigned vel_w);
    return time_w + 2 * vel_w + 1;
  endfunction

  // Position accumulator holds the integer position plus its fraction
  function automatic int unsigned acc_w(int unsigned pos_w, int unsigned frac_w);
    return pos_w + frac_w;
  endfunction

endpackage

// File: rtl/stepper_cmd_fifo.sv
// Synchronous command FIFO with first-word fall-through read.
//   clk, reset_n : clock, asynchronous active-low reset
//   push, wr_data: write one word (ignored when full or flushing)
//   pop          : drop the head word (ignored when empty or flushing)
//   flush        : discard all entries
//   rd_data_c    : current head word (combinational read of storage)
//   not_full     : registered, 1 when a push can be accepted
//   empty        : registered, 1 when no entries are held
//   level        : registered occupancy
module stepper_cmd_fifo #(
  parameter int unsigned W     = 97,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data_c,
  output logic                     not_full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic [LW-1:0] level_n;

  // Qualified push/pop and next occupancy
  always_comb begin
    do_push = push && not_full && !flush;
    do_pop  = pop && !empty && !flush;
    level_n = level;
    if (flush) begin
      level_n = '0;
    end else if (do_push && !do_pop) begin
      level_n = level + LW'(1);
    end else if (!do_push && do_pop) begin
      level_n = level - LW'(1);
    end
  end

  // Pointers and status flags; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      not_full <= 1'b1;
      empty    <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      level    <= level_n;
      not_full <= (level_n != LW'(DEPTH));
      empty    <= (level_n == '0);
    end
  end

  // Storage needs no reset: entries are only read when counted valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/stepper_seq_ctrl.sv
// One stepper axis driven by queued constant-acceleration segments.
// A DDA integrator adds velocity into a fixed-point position every RUN cycle
// and adds acceleration into velocity (saturated at +/-VMAX). Segments chain
// without bubbles; running dry while still moving forces a flagged stop.
//   clk, reset_n    : clock, asynchronous active-low reset
//   cmd_valid/ready : command handshake into the segment FIFO
//   cmd_time        : segment length in cycles (0 runs for one cycle)
//   cmd_acc         : signed per-cycle acceleration
//   cmd_vel         : signed start velocity, loaded only with cmd_set_vel
//   set_position    : load integer position from data_in while idle
//   abort           : flush queue and stop at the next edge
//   clear_underrun  : clear the sticky underrun flag
//   position        : integer part of the position accumulator
//   velocity, acc   : current velocity / active segment acceleration
//   dir, step       : driver pins; one step pulse per integer crossing
//   busy            : a segment is executing
//   seg_done        : high during the last cycle of each segment
//   underrun        : sticky, queue ran dry while still moving
//   level           : FIFO occupancy
module stepper_seq_ctrl
  import stepper_seq_ctrl_pkg::*;
#(
  parameter int unsigned POS_W      = 32,
  parameter int unsigned FRAC_W     = 16,
  parameter int unsigned VEL_W      = 32,
  parameter int unsigned TIME_W     = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STEP_PULSE = 4,
  parameter int          VMAX       = 8192
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [TIME_W-1:0]        cmd_time,
  input  logic [VEL_W-1:0]         cmd_acc,
  input  logic [VEL_W-1:0]         cmd_vel,
  input  logic                     cmd_set_vel,
  input  logic                     set_position,
  input  logic [POS_W-1:0]         data_in,
  input  logic                     abort,
  input  logic                     clear_underrun,
  output logic [POS_W-1:0]         position,
  output logic [VEL_W-1:0]         velocity,
  output logic [VEL_W-1:0]         acc,
  output logic                     dir,
  output logic                     step,
  output logic                     busy,
  output logic                     seg_done,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned ACC_W   = acc_w(POS_W, FRAC_W);
  localparam int unsigned CMD_W   = cmd_word_w(TIME_W, VEL_W);
  localparam int unsigned OFF_ACC = TIME_W;
  localparam int unsigned OFF_VEL = TIME_W + VEL_W;
  localparam int unsigned OFF_SET = TIME_W + 2 * VEL_W;
  localparam int unsigned PW      = $clog2(STEP_PULSE + 1);

  localparam logic signed [VEL_W:0] VMAX_S = (VEL_W+1)'(VMAX);

  // FIFO interface
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  logic              fifo_empty;
  logic              fifo_not_full;
  logic [CMD_W-1:0]  cmd_word;
  logic [CMD_W-1:0]  head;

  // Decoded head-of-queue segment
  logic [TIME_W-1:0] head_len;
  logic [VEL_W-1:0]  head_acc;
  logic [VEL_W-1:0]  head_vel;
  logic              head_set_vel;

  // FSM and integrator state
  state_t                   state;
  state_t                   state_n;
  logic [TIME_W-1:0]        tcnt;
  logic [TIME_W-1:0]        tcnt_n;
  logic signed [VEL_W-1:0]  acc_q;
  logic signed [VEL_W-1:0]  acc_n;
  logic signed [VEL_W-1:0]  vel_q;
  logic signed [VEL_W-1:0]  vel_n;
  logic signed [ACC_W-1:0]  pos_q;
  logic signed [ACC_W-1:0]  pos_n;
  logic signed [ACC_W-1:0]  pos_step;
  logic signed [VEL_W:0]    vel_sum;
  logic signed [VEL_W-1:0]  vel_sat;
  logic                     underrun_n;
  logic                     seg_n;
  logic                     busy_n;

  // Step pulse shaper
  logic                     step_evt;
  logic                     step_evt_dir;
  logic                     s1_valid;
  logic                     s1_dir;
  logic                     s2_valid;
  logic [PW-1:0]            pcnt;

  assign cmd_word  = {cmd_set_vel, cmd_vel, cmd_acc, cmd_time};
  assign fifo_push = cmd_valid && fifo_not_full;
  assign cmd_ready = fifo_not_full;

  stepper_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .wr_data   (cmd_word),
    .rd_data_c (head),
    .not_full  (fifo_not_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  // Head segment fields; a zero length still runs for one cycle
  always_comb begin
    head_acc     = head[OFF_ACC +: VEL_W];
    head_vel     = head[OFF_VEL +: VEL_W];
    head_set_vel = head[OFF_SET];
    head_len     = (head[TIME_W-1:0] == '0) ? TIME_W'(1) : head[TIME_W-1:0];
  end

  // Integrator arithmetic: position uses the old velocity, velocity saturates
  always_comb begin
    pos_step = pos_q + ACC_W'(vel_q);
    vel_sum  = (VEL_W+1)'(vel_q) + (VEL_W+1)'(acc_q);
    if (vel_sum > VMAX_S) begin
      vel_sat = VEL_W'(VMAX_S);
    end else if (vel_sum < -VMAX_S) begin
      vel_sat = VEL_W'(-VMAX_S);
    end else begin
      vel_sat = VEL_W'(vel_sum);
    end
  end

  // Segment FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Segment FSM next-state and datapath updates
  always_comb begin
    state_n      = state;
    tcnt_n       = tcnt;
    acc_n        = acc_q;
    vel_n        = vel_q;
    pos_n        = pos_q;
    underrun_n   = underrun && !clear_underrun;
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;
    step_evt     = 1'b0;
    step_evt_dir = !vel_q[VEL_W-1];
    seg_n        = 1'b0;
    busy_n       = 1'b0;

    if (abort) begin
      fifo_flush = 1'b1;
      vel_n      = '0;
      acc_n      = '0;
      state_n    = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (set_position) begin
            pos_n = {data_in, {FRAC_W{1'b0}}};
          end
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_n  = ST_RUN;
            tcnt_n   = head_len;
            acc_n    = head_acc;
            if (head_set_vel) vel_n = head_vel;
          end
        end
        ST_RUN: begin
          pos_n    = pos_step;
          vel_n    = vel_sat;
          tcnt_n   = tcnt - TIME_W'(1);
          step_evt = (pos_step[ACC_W-1:FRAC_W] != pos_q[ACC_W-1:FRAC_W]);
          if (tcnt == TIME_W'(1)) begin
            if (!fifo_empty) begin
              // Chain straight into the next segment, no idle cycle
              fifo_pop = 1'b1;
              tcnt_n   = head_len;
              acc_n    = head_acc;
              if (head_set_vel) vel_n = head_vel;
            end else begin
              if (vel_sat != '0) underrun_n = 1'b1;
              vel_n   = '0;
              acc_n   = '0;
              state_n = ST_IDLE;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end

    // Look ahead so seg_done is a register that is high while tcnt==1
    busy_n = (state_n == ST_RUN);
    seg_n  = busy_n && (tcnt_n == TIME_W'(1));
  end

  // Integrator and status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt     <= '0;
      acc_q    <= '0;
      vel_q    <= '0;
      pos_q    <= '0;
      underrun <= 1'b0;
      seg_done <= 1'b0;
      busy     <= 1'b0;
    end else begin
      tcnt     <= tcnt_n;
      acc_q    <= acc_n;
      vel_q    <= vel_n;
      pos_q    <= pos_n;
      underrun <= underrun_n;
      seg_done <= seg_n;
      busy     <= busy_n;
    end
  end

  // Step shaper: dir settles one cycle before the pulse rises.
  // VMAX keeps crossings at least 2*STEP_PULSE apart, so pulses never overlap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_dir   <= 1'b0;
      s2_valid <= 1'b0;
      dir      <= 1'b0;
      step     <= 1'b0;
      pcnt     <= '0;
    end else begin
      s1_valid <= step_evt;
      s1_dir   <= step_evt_dir;
      s2_valid <= s1_valid;
      if (s1_valid) dir <= s1_dir;
      if (s2_valid) begin
        step <= 1'b1;
        pcnt <= PW'(STEP_PULSE - 1);
      end else if (pcnt != '0) begin
        pcnt <= pcnt - PW'(1);
      end else begin
        step <= 1'b0;
      end
    end
  end

  assign position = pos_q[ACC_W-1:FRAC_W];
  assign velocity = vel_q;
  assign acc      = acc_q;

endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// Bench for stepper_seq_ctrl: a queue-based behavioural axis model is stepped
// every clock and compared against all DUT outputs, plus directed scenarios
// with hand-computed results and a randomized command phase.
module tb_stepper_seq_ctrl;

  localparam int POS_W  = 32;
  localparam int FRAC_W = 16;
  localparam int VEL_W  = 32;
  localparam int TIME_W = 32;
  localparam int DEPTH  = 4;
  localparam int SP     = 4;
  localparam int VMAX   = 8192;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int SHIFT  = 64 - (POS_W + FRAC_W);

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [TIME_W-1:0]   cmd_time = '0;
  logic [VEL_W-1:0]    cmd_acc = '0;
  logic [VEL_W-1:0]    cmd_vel = '0;
  logic                cmd_set_vel = 1'b0;
  logic                set_position = 1'b0;
  logic [POS_W-1:0]    data_in = '0;
  logic                abort = 1'b0;
  logic                clear_underrun = 1'b0;
  logic [POS_W-1:0]    position;
  logic [VEL_W-1:0]    velocity;
  logic [VEL_W-1:0]    acc;
  logic                dir;
  logic                step;
  logic                busy;
  logic                seg_done;
  logic                underrun;
  logic [LW-1:0]       level;

  always #5 clk = ~clk;

  stepper_seq_ctrl #(
    .POS_W(POS_W), .FRAC_W(FRAC_W), .VEL_W(VEL_W), .TIME_W(TIME_W),
    .DEPTH(DEPTH), .STEP_PULSE(SP), .VMAX(VMAX)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_time(cmd_time),
    .cmd_acc(cmd_acc), .cmd_vel(cmd_vel), .cmd_set_vel(cmd_set_vel),
    .set_position(set_position), .data_in(data_in), .abort(abort),
    .clear_underrun(clear_underrun), .position(position), .velocity(velocity),
    .acc(acc), .dir(dir), .step(step), .busy(busy), .seg_done(seg_done),
    .underrun(underrun), .level(level)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    longint t;
    longint a;
    longint v;
    bit     sv;
  } cmd_t;

  cmd_t   mq[$];
  bit     m_run;
  longint m_rem, m_vel, m_acc, m_pos;
  bit     m_und;
  bit     m_dir, m_step;
  bit     m_accepted;
  longint k;
  longint ev_e[$];
  bit     ev_d[$];

  int checks = 0;
  int errors = 0;

  // Observation helpers (all fed from DUT outputs)
  int     step_cnt = 0;
  int     seg_cnt = 0;
  longint seg_q[$];
  longint peak_vel = 0;
  bit     saw_full = 0;

  function automatic longint clamp(longint x);
    if (x > VMAX) return VMAX;
    if (x < -VMAX) return -VMAX;
    return x;
  endfunction

  function automatic int ipart(longint p);
    return int'(p >>> FRAC_W);
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    ev_e.delete();
    ev_d.delete();
    m_run = 0; m_rem = 0; m_vel = 0; m_acc = 0; m_pos = 0;
    m_und = 0; m_dir = 0; m_step = 0; m_accepted = 0;
  endtask

  task automatic start_seg(cmd_t c);
    m_rem = (c.t == 0) ? 1 : c.t;
    m_acc = c.a;
    if (c.sv) m_vel = c.v;
    m_run = 1;
  endtask

  task automatic model_edge();
    bit     ready;
    longint np;
    int     d;
    cmd_t   c;
    k++;
    ready = (mq.size() < DEPTH);
    m_accepted = 0;
    if (clear_underrun) m_und = 0;
    if (abort) begin
      mq.delete();
      m_vel = 0;
      m_acc = 0;
      m_run = 0;
    end else if (!m_run) begin
      if (set_position) m_pos = longint'($signed(data_in)) * (longint'(1) << FRAC_W);
      if (mq.size() > 0) begin
        c = mq.pop_front();
        start_seg(c);
      end
    end else begin
      np = m_pos + m_vel;
      np = (np <<< SHIFT) >>> SHIFT;
      d  = ipart(np) - ipart(m_pos);
      if (d != 0) begin
        ev_e.push_back(k);
        ev_d.push_back(d > 0);
      end
      m_pos = np;
      m_vel = clamp(m_vel + m_acc);
      m_rem--;
      if (m_rem == 0) begin
        if (mq.size() > 0) begin
          c = mq.pop_front();
          start_seg(c);
        end else begin
          if (m_vel != 0) m_und = 1;
          m_vel = 0;
          m_acc = 0;
          m_run = 0;
        end
      end
    end
    if (cmd_valid && ready && !abort) begin
      c.t  = longint'(cmd_time);
      c.a  = longint'($signed(cmd_acc));
      c.v  = longint'($signed(cmd_vel));
      c.sv = cmd_set_vel;
      mq.push_back(c);
      m_accepted = 1;
    end
    // Step events: dir follows one edge later, pulse spans edges e+2..e+1+SP
    m_step = 0;
    foreach (ev_e[i]) begin
      if (ev_e[i] + 1 == k) m_dir = ev_d[i];
      if (ev_e[i] + 2 <= k && k <= ev_e[i] + 1 + SP) m_step = 1;
    end
    while (ev_e.size() > 0 && ev_e[0] + 1 + SP <= k) begin
      void'(ev_e.pop_front());
      void'(ev_d.pop_front());
    end
  endtask

  task automatic compare_all();
    chk("position", longint'($signed(position)), longint'(ipart(m_pos)));
    chk("velocity", longint'($signed(velocity)), m_vel);
    chk("acc", longint'($signed(acc)), m_run ? m_acc : 0);
    chk("busy", longint'(busy), longint'(m_run));
    chk("seg_done", longint'(seg_done), longint'(m_run && m_rem == 1));
    chk("underrun", longint'(underrun), longint'(m_und));
    chk("level", longint'(level), longint'(mq.size()));
    chk("cmd_ready", longint'(cmd_ready), longint'(mq.size() < DEPTH));
    chk("dir", longint'(dir), longint'(m_dir));
    chk("step", longint'(step), longint'(m_step));
  endtask

  // Model advance and per-cycle comparison, sampled 1 time unit after the edge
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_edge();
    #1;
    compare_all();
    if (seg_done) begin
      seg_cnt++;
      seg_q.push_back(k);
    end
    if ($signed(velocity) > peak_vel) peak_vel = longint'($signed(velocity));
    if (level == LW'(DEPTH) && !cmd_ready) saw_full = 1;
  end

  always @(posedge step) step_cnt++;

  // ---------------- stimulus helpers ----------------
  task automatic push_cmd(longint t, longint a, longint v, bit sv);
    int n;
    n = 0;
    cmd_valid   = 1'b1;
    cmd_time    = TIME_W'(t);
    cmd_acc     = VEL_W'(a);
    cmd_vel     = VEL_W'(v);
    cmd_set_vel = sv;
    forever begin
      @(negedge clk);
      n++;
      if (m_accepted) break;
      if (n > 3000) begin
        checks++;
        errors++;
        $display("FAIL push_timeout: got no accept expected accept at %0t", $time);
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(int max_cycles);
    int n;
    n = 0;
    while (m_run || mq.size() > 0) begin
      @(negedge clk);
      n++;
      if (n > max_cycles) begin
        checks++;
        errors++;
        $display("FAIL idle_timeout: got busy expected idle at %0t", $time);
        break;
      end
    end
  endtask

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_setpos(longint p);
    set_position = 1'b1;
    data_in      = POS_W'(p);
    @(negedge clk);
    set_position = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_underrun = 1'b1;
    @(negedge clk);
    clear_underrun = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   times[5];
    longint a, v, t;
    model_reset();
    k = 0;
    cycles(3);
    reset_n = 1'b1;
    cycles(2);

    // Reset asserted mid-motion clears everything asynchronously
    push_cmd(800, 0, 32'h2000, 1);
    cycles(50);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_position", longint'(position), 0);
    chk("rst_velocity", longint'(velocity), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_cmd_ready", longint'(cmd_ready), 1);
    chk("rst_level", longint'(level), 0);
    chk("rst_step", longint'(step), 0);
    @(negedge clk);
    reset_n = 1'b1;
    cycles(2);

    // Constant velocity run of 800 cycles ending in an underrun
    step_cnt = 0; seg_cnt = 0;
    push_cmd(800, 0, 32'h2000, 1);
    wait_idle(1000);
    cycles(8);
    chk("t2_steps", step_cnt, 100);
    chk("t2_position", longint'($signed(position)), 100);
    chk("t2_seg_done", seg_cnt, 1);
    chk("t2_underrun", longint'(underrun), 1);
    chk("t2_velocity", longint'($signed(velocity)), 0);
    chk("t2_dir", longint'(dir), 1);
    pulse_clear();
    chk("t2_clear", longint'(underrun), 0);

    // Triangular profile: accelerate then decelerate back to rest
    pulse_setpos(0);
    seg_cnt = 0; seg_q.delete(); peak_vel = 0;
    push_cmd(512, 16, 0, 1);
    push_cmd(512, -16, 0, 0);
    wait_idle(1200);
    cycles(8);
    chk("t3_position", longint'($signed(position)), 64);
    chk("t3_peak_vel", peak_vel, 8192);
    chk("t3_velocity", longint'($signed(velocity)), 0);
    chk("t3_underrun", longint'(underrun), 0);
    chk("t3_seg_cnt", seg_cnt, 2);
    if (seg_q.size() == 2) chk("t3_gap", seg_q[1] - seg_q[0], 512);
    else chk("t3_seg_q", seg_q.size(), 2);

    // Negative run from position 10; set_position while busy is ignored
    pulse_setpos(10);
    chk("t4_setpos", longint'($signed(position)), 10);
    step_cnt = 0;
    push_cmd(80, 0, -32'sh2000, 1);
    cycles(10);
    pulse_setpos(555);
    wait_idle(200);
    cycles(8);
    chk("t4_position", longint'($signed(position)), 0);
    chk("t4_steps", step_cnt, 10);
    chk("t4_dir", longint'(dir), 0);
    chk("t4_underrun", longint'(underrun), 1);

    // Fill the queue while busy; seg_done spacing follows each length
    times = '{7, 0, 13, 5, 9};
    seg_q.delete(); saw_full = 0;
    push_cmd(200, 0, 0, 1);
    foreach (times[i]) push_cmd(times[i], 0, 0, 1);
    wait_idle(500);
    chk("t5_saw_full", longint'(saw_full), 1);
    chk("t5_seg_cnt", seg_q.size(), 6);
    if (seg_q.size() == 6) begin
      foreach (times[i]) chk("t5_spacing", seg_q[i+1] - seg_q[i], (times[i] == 0) ? 1 : times[i]);
    end

    // Abort mid-segment with two queued entries
    push_cmd(300, 0, 32'h1000, 1);
    push_cmd(50, 0, 0, 1);
    push_cmd(50, 0, 0, 1);
    cycles(20);
    pulse_abort();
    chk("t6_busy", longint'(busy), 0);
    chk("t6_level", longint'(level), 0);
    chk("t6_velocity", longint'($signed(velocity)), 0);
    chk("t6_underrun_kept", longint'(underrun), 1);
    pulse_clear();
    chk("t6_clear", longint'(underrun), 0);
    cycles(10);

    // Randomized commands, gaps, aborts, position loads and flag clears
    for (int it = 0; it < 30; it++) begin
      if (!m_run && $urandom_range(0, 3) == 0) pulse_setpos(longint'($signed($urandom())));
      for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
        t = longint'($urandom_range(0, 150));
        a = longint'($urandom_range(0, 80)) - 40;
        v = longint'($urandom_range(0, 2 * VMAX)) - VMAX;
        push_cmd(t, a, v, $urandom_range(0, 1) == 1);
      end
      cycles(int'($urandom_range(0, 60)));
      if ($urandom_range(0, 4) == 0) pulse_abort();
      if ($urandom_range(0, 3) == 0) pulse_clear();
      if ($urandom_range(0, 1) == 0) wait_idle(3000);
    end
    wait_idle(3000);
    cycles(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
